psdsquare: RTL

- Sequential shift-and-add squarer: computes xin*xin, one partial product per clock, using a start/busy/done handshake.
- Inverse companion of the sequential square-root block. It drives round-trip checks (sqrt(x)^2 <= x) and is used wherever a registered integer square is needed.
- Small area, no hardware multiplier. Latency is NBITSIN iterations.

---
 rtl/psdsquare.sv | 63 ++++++
 1 files changed

// File: rtl/psdsquare.sv
// psdsquare: sequential shift-and-add squarer, one partial product per clock; PSDSQUARE_EARLY_EXIT_EN ends once the multiplier is exhausted
module psdsquare #(
    parameter int NBITSIN = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NBITSIN-1:0]     xin,
    output logic                   busy,
    output logic                   done,
    output logic [2*NBITSIN-1:0]   sq
);
    localparam int CW = $clog2(NBITSIN + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [2*NBITSIN-1:0] a, acc, acc_nx;
    logic [NBITSIN-1:0] b;
    logic [CW-1:0] cnt;
    logic last;
    always_comb begin
        acc_nx = acc + (b[0] ? a : '0);
`ifdef PSDSQUARE_EARLY_EXIT_EN
        last = (b >> 1) == '0 || cnt == CW'(NBITSIN - 1);
`else
        last = cnt == CW'(NBITSIN - 1);
`endif
        state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a <= '0;
            b <= '0;
            acc <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            sq <= '0;
        end else begin
            state <= state_nx;
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    a <= {{NBITSIN{1'b0}}, xin};
                    b <= xin;
                    acc <= '0;
                    cnt <= '0;
                    busy <= 1'b1;
                end
            end else begin
                acc <= acc_nx;
                a <= a << 1;
                b <= b >> 1;
                cnt <= cnt + CW'(1);
                if (last) begin
                    sq <= acc_nx;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule
